// File: rtl/instr_encoder.sv
// Instruction encoder: accepts decoded field bundles, packs them into 16-bit
// instruction words and writes them to consecutive instruction-memory addresses.
module instr_encoder #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [3:0]        rd,
    input  logic [3:0]        rs,
    input  logic [3:0]        rt,
    input  logic [2:0]        cond,
    input  logic [15:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       word_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_XOR    = 4'h2;
    localparam logic [3:0] OP_RED    = 4'h3;
    localparam logic [3:0] OP_SLL    = 4'h4;
    localparam logic [3:0] OP_SRA    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LHB    = 4'hA;
    localparam logic [3:0] OP_LLB    = 4'hB;
    localparam logic [3:0] OP_B      = 4'hC;
    localparam logic [3:0] OP_BR     = 4'hD;
    localparam logic [3:0] OP_PCS    = 4'hE;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              hlt_q, hlt_d;
    logic [15:0]       enc;
    logic              range_ok;

    // Signed ranges are checked by requiring the dropped upper bits to be a pure sign extension.
    always_comb begin
        enc      = 16'h0000;
        range_ok = 1'b1;
        case (op)
            OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB: begin
                enc = {op, rd, rs, rt};
            end
            OP_SLL, OP_SRA, OP_ROR: begin
                enc      = {op, rd, rs, imm[3:0]};
                range_ok = (imm[15:4] == 12'h000);
            end
            OP_LW, OP_SW: begin
                enc      = {op, rt, rs, imm[3:0]};
                range_ok = (imm[15:3] == 13'h0000) || (imm[15:3] == 13'h1FFF);
            end
            OP_LHB, OP_LLB: begin
                enc      = {op, rd, imm[7:0]};
                range_ok = (imm[15:8] == 8'h00);
            end
            OP_B: begin
                enc      = {op, cond, imm[8:0]};
                range_ok = (imm[15:8] == 8'h00) || (imm[15:8] == 8'hFF);
            end
            OP_BR: begin
                enc = {op, cond, 1'b0, rs, 4'h0};
            end
            OP_PCS: begin
                enc = {op, rd, 8'h00};
            end
            default: begin
                enc = 16'hF000;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        hlt_d   = hlt_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    ptr_d   = base_addr;
                    cnt_d   = 16'h0000;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (in_valid) begin
                    if (range_ok) begin
                        addr_d  = ptr_q;
                        wdata_d = enc;
                        hlt_d   = (op == 4'hF);
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_WRITE: begin
                ptr_d   = ptr_q + ADDR_W'(2);
                cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'h0001;
                state_d = hlt_q ? S_DONE : S_RUN;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= 16'h0000;
            addr_q  <= '0;
            wdata_q <= 16'h0000;
            hlt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hlt_q   <= hlt_d;
        end
    end

    assign in_ready  = (state_q == S_RUN);
    assign mem_we    = (state_q == S_WRITE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q == S_RUN) || (state_q == S_WRITE);
    assign done      = (state_q == S_DONE);
    assign err       = (state_q == S_ERR);
    assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed bundles push expected writes,
// a negedge monitor pops and compares every memory write strobe.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] base_addr = 16'h0000;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = 4'h0;
    logic [3:0]  rd = 4'h0;
    logic [3:0]  rs = 4'h0;
    logic [3:0]  rt = 4'h0;
    logic [2:0]  cond = 3'h0;
    logic [15:0] imm = 16'h0000;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] word_cnt;

    int n_compared = 0;
    int n_mismatched = 0;
    logic [31:0] sb[$];

    instr_encoder #(.ADDR_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rd(rd), .rs(rs), .rt(rt), .cond(cond), .imm(imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every write strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_write", {mem_addr, mem_wdata}, 32'h0);
                n_compared = n_compared;
            end else begin
                logic [31:0] exp_w;
                exp_w = sb.pop_front();
                checkOutput("write_addr", {16'h0, mem_addr}, {16'h0, exp_w[31:16]});
                checkOutput("write_data", {16'h0, mem_wdata}, {16'h0, exp_w[15:0]});
            end
        end
    end

    task automatic doStart(input logic [15:0] base);
        @(negedge clk);
        start = 1'b1;
        base_addr = base;
        @(negedge clk);
        start = 1'b0;
        checkOutput("start_in_ready", {31'h0, in_ready}, 32'h1);
        checkOutput("start_word_cnt", {16'h0, word_cnt}, 32'h0);
    endtask

    task automatic applyStimulus(input logic [3:0] f_op, input logic [3:0] f_rd, input logic [3:0] f_rs,
                                 input logic [3:0] f_rt, input logic [2:0] f_cond, input logic [15:0] f_imm,
                                 input bit exp_write, input logic [15:0] exp_addr, input logic [15:0] exp_data);
        int n;
        @(negedge clk);
        op = f_op; rd = f_rd; rs = f_rs; rt = f_rt; cond = f_cond; imm = f_imm;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            checkOutput("handshake_timeout", {31'h0, in_ready}, 32'h1);
            in_valid = 1'b0;
        end else begin
            if (exp_write) sb.push_back({exp_addr, exp_data});
            @(posedge clk);
            #1 in_valid = 1'b0;
            if (exp_write) begin
                @(negedge clk);
                checkOutput("write_latency", {31'h0, mem_we}, 32'h1);
            end
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_in_ready"}, {31'h0, in_ready}, 32'h0);
        checkOutput({tag, "_mem_we"}, {31'h0, mem_we}, 32'h0);
        checkOutput({tag, "_mem_addr"}, {16'h0, mem_addr}, 32'h0);
        checkOutput({tag, "_mem_wdata"}, {16'h0, mem_wdata}, 32'h0);
        checkOutput({tag, "_word_cnt"}, {16'h0, word_cnt}, 32'h0);
        checkOutput({tag, "_busy_done_err"}, {29'h0, busy, done, err}, 32'h0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst = 1'b0;

        // Basic ADD and the word counter.
        doStart(16'h0040);
        checkOutput("run_busy", {31'h0, busy}, 32'h1);
        applyStimulus(4'h0, 4'd3, 4'd4, 4'd5, 3'd0, 16'h0000, 1'b1, 16'h0040, 16'h0345);
        @(negedge clk);
        checkOutput("word_cnt_after_add", {16'h0, word_cnt}, 32'h1);

        // Immediate formats, including range boundaries and ignored fields.
        applyStimulus(4'hB, 4'd2, 4'd9, 4'd9, 3'd7, 16'h00A5, 1'b1, 16'h0042, 16'hB2A5);
        applyStimulus(4'h8, 4'd7, 4'd2, 4'd1, 3'd0, 16'hFFFE, 1'b1, 16'h0044, 16'h812E);
        applyStimulus(4'hC, 4'd5, 4'd5, 4'd5, 3'd3, 16'hFFFF, 1'b1, 16'h0046, 16'hC7FF);
        applyStimulus(4'hE, 4'd7, 4'd3, 4'd4, 3'd6, 16'h1234, 1'b1, 16'h0048, 16'hE700);
        applyStimulus(4'hD, 4'd8, 4'd9, 4'd1, 3'd5, 16'hFFFF, 1'b1, 16'h004A, 16'hDA90);
        applyStimulus(4'h5, 4'd1, 4'd2, 4'd3, 3'd0, 16'h000F, 1'b1, 16'h004C, 16'h512F);
        applyStimulus(4'h9, 4'd0, 4'd4, 4'd3, 3'd0, 16'h0007, 1'b1, 16'h004E, 16'h9347);
        applyStimulus(4'hA, 4'd4, 4'd0, 4'd0, 3'd0, 16'h00FF, 1'b1, 16'h0050, 16'hA4FF);
        applyStimulus(4'hC, 4'd0, 4'd0, 4'd0, 3'd0, 16'hFF00, 1'b1, 16'h0052, 16'hC100);

        // HLT ends the program; later bundles must be ignored.
        applyStimulus(4'hF, 4'd6, 4'd6, 4'd6, 3'd6, 16'h5555, 1'b1, 16'h0054, 16'hF000);
        @(negedge clk);
        checkOutput("hlt_done", {31'h0, done}, 32'h1);
        checkOutput("hlt_in_ready", {31'h0, in_ready}, 32'h0);
        checkOutput("hlt_word_cnt", {16'h0, word_cnt}, 32'd11);
        in_valid = 1'b1;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        checkOutput("done_sticky", {31'h0, done}, 32'h1);

        // Out-of-range shift amount.
        doStart(16'h1000);
        applyStimulus(4'h4, 4'd1, 4'd1, 4'd0, 3'd0, 16'h0010, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        checkOutput("sll_err", {31'h0, err}, 32'h1);
        checkOutput("sll_word_cnt", {16'h0, word_cnt}, 32'h0);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("err_in_ready", {31'h0, in_ready}, 32'h0);
        end
        in_valid = 1'b0;

        // Out-of-range memory offset and branch offset.
        doStart(16'h2000);
        applyStimulus(4'h8, 4'd0, 4'd1, 4'd2, 3'd0, 16'hFFF7, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        checkOutput("lw_err", {31'h0, err}, 32'h1);
        doStart(16'h2000);
        applyStimulus(4'hC, 4'd0, 4'd0, 4'd0, 3'd1, 16'h0100, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        checkOutput("b_err", {31'h0, err}, 32'h1);

        // Pointer wraps past the top of the address space.
        doStart(16'hFFFE);
        applyStimulus(4'h1, 4'hA, 4'hB, 4'hC, 3'd0, 16'h0000, 1'b1, 16'hFFFE, 16'h1ABC);
        applyStimulus(4'h2, 4'd1, 4'd1, 4'd1, 3'd0, 16'h0000, 1'b1, 16'h0000, 16'h2111);
        @(negedge clk);
        checkOutput("wrap_word_cnt", {16'h0, word_cnt}, 32'h2);

        // Reset arriving while a write is on the bus.
        applyStimulus(4'h0, 4'd1, 4'd2, 4'd3, 3'd0, 16'h0000, 1'b1, 16'h0002, 16'h0123);
        rst = 1'b1;
        @(negedge clk);
        checkResetValues("mid_write_reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        checkOutput("scoreboard_empty", sb.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter ADDR_W, default 16: width of the instruction-memory byte address.
REQ-002 Port clk, input, 1: single clock, all state updates on its rising edge.
REQ-003 Port rst, input, 1: reset, synchronous and active-high.
REQ-004 Port start, input, 1: one-cycle pulse that begins a program load; sampled only in IDLE, DONE or ERR.
REQ-005 Port base_addr, input, ADDR_W: byte address of the first instruction; latched on start.
REQ-006 Port in_valid, input, 1: field bundle below is valid.
REQ-007 Port in_ready, output, 1: encoder accepts a bundle this cycle.
REQ-008 Port op, input, 4: opcode, 0000 ADD through 1111 HLT (16-entry ISA map).
REQ-009 Ports rd, rs, rt, input, 4 each: register specifiers.
REQ-010 Port cond, input, 3: branch condition code for B/BR.
REQ-011 Port imm, input, 16: signed two's-complement immediate or offset.
REQ-012 Port mem_we, output, 1: one-cycle instruction-memory write strobe.
REQ-013 Port mem_addr, output, ADDR_W: byte address of the write.
REQ-014 Port mem_wdata, output, 16: encoded instruction word.
REQ-015 Port busy, output, 1: high in RUN and WRITE.
REQ-016 Ports done and err, output, 1 each: sticky status flags, cleared by start or rst.
REQ-017 Port word_cnt, output, 16: number of words written since the last start.

Function
REQ-018 FSM states: IDLE, RUN, WRITE, DONE, ERR.
REQ-019 start in IDLE, DONE or ERR: latch base_addr into the address pointer, clear word_cnt, done and err, then go to RUN.
REQ-020 in_ready is 1 only in RUN; a handshake occurs when in_valid and in_ready are both 1 in the same cycle.
REQ-021 On a handshake, encode the bundle and register it; next cycle go to WRITE, or to ERR if the range check fails.
REQ-022 WRITE lasts one cycle: mem_we=1, mem_addr=pointer, mem_wdata=encoded word; then pointer+=2 (wraps modulo 2^ADDR_W) and word_cnt+=1 (saturates at 0xFFFF).
REQ-023 After WRITE go to DONE if op was HLT, else return to RUN; latency is handshake at cycle N, mem_we at N+1, peak throughput one word per 2 cycles.
REQ-024 Encodings for ADD, SUB, RED, XOR, PADDSB: op|rd|rs|rt.
REQ-025 Encodings for SLL, SRA, ROR: op|rd|rs|imm[3:0]; imm must be in 0..15.
REQ-026 Encodings for LW, SW: op|rt|rs|imm[3:0]; imm must be in -8..7.
REQ-027 Encodings for LHB, LLB: op|rd|imm[7:0]; imm must be in 0..255.
REQ-028 Encoding for B: op|cond|imm[8:0]; imm must be in -256..255.
REQ-029 Encoding for BR: op|cond|0|rs|0000.
REQ-030 Encoding for PCS: op|rd|0x00.
REQ-031 Encoding for HLT: 0xF000.
REQ-032 Unused fields are encoded as zero regardless of input values.
REQ-033 On a range violation: enter ERR, set err=1, assert no mem_we, leave word_cnt unchanged.
REQ-034 in_valid outside RUN is ignored; a start in RUN or WRITE is ignored.
REQ-035 mem_wdata and mem_addr hold their last values when mem_we=0.
REQ-036 done is high in DONE; err is high in ERR.

Reset
REQ-037 rst has priority over all inputs, including mid-WRITE; the pending write is dropped.
REQ-038 Reset values: state IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, pointer=0, word_cnt=0, busy=0, done=0, err=0.

Verification
REQ-039 start with base=0x0040, then ADD rd=3 rs=4 rt=5 -> mem_we at handshake+1, addr 0x0040, data 0x0345, word_cnt=1.
REQ-040 Send LLB rd=2 imm=0xA5, then LW rt=1 rs=2 imm=-2, then B cond=3 imm=-1 -> data 0xB2A5, 0x812E, 0xC7FF at consecutive addresses +2.
REQ-041 Send SLL imm=16 -> err=1, no mem_we, in_ready=0 until the next start.
REQ-042 Send HLT -> data 0xF000, then done=1 and in_ready=0, and further in_valid produces no writes.
REQ-043 Assert rst during WRITE -> mem_we=0 next cycle and all outputs at their reset values.
REQ-044 base=0xFFFE with two words -> second write at address 0x0000.
